// File: rtl/led_fader_pkg.sv
// Shared encodings for the LED fade engine: runtime modes, fade FSM states
// and the channel-select width helper.
package led_fader_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_SEQ    = 2'd1,
    MODE_SYNC   = 2'd2,
    MODE_STATIC = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RISE = 2'd1,
    ST_FALL = 2'd2
  } state_e;

  // Channel index width; a single channel still gets a 1-bit select.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fader_pwm.sv
// Single-channel PWM with a shadow duty register reloaded only at the period
// boundary, driven from a shared counter so all channels stay phase-aligned.
module fader_pwm #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm
);

  logic [WIDTH-1:0] active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      if (cnt == '1) begin
        active <= duty;
      end
      pwm <= (cnt < active);
    end
  end

endmodule

// File: rtl/led_fader.sv
// Multi-channel LED fade engine: prescaled fade FSM with sequential, synchronous
// and static modes feeding phase-aligned per-channel PWM outputs.
module led_fader
  import led_fader_pkg::*;
#(
  parameter  int unsigned CHANNELS = 3,
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned PEAK     = 32,
  parameter  int unsigned DIVIDER  = 256,
  localparam int unsigned SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [1:0]                i_mode,
  input  logic [CHANNELS*WIDTH-1:0] i_static,
  output logic [CHANNELS-1:0]       o_pwm,
  output logic [CHANNELS-1:0]       o_led_n,
  output logic [SEL_W-1:0]          o_channel,
  output logic                      o_cycle
);

  localparam int unsigned PRE_W = $clog2(DIVIDER);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIVIDER - 1);
  localparam logic [WIDTH-1:0] PEAK_L   = WIDTH'(PEAK);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);

  logic [PRE_W-1:0] pres;
  logic [WIDTH-1:0] pwm_cnt;
  logic [WIDTH-1:0] level_q, level_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  state_e           state_q, state_d;
  mode_e            mode_q, mode_in;
  logic             change, tick, cycle_pulse;
  logic [WIDTH-1:0] duty [CHANNELS];

  assign mode_in = mode_e'(i_mode);
  assign change  = (mode_in != mode_q);
  assign tick    = (pres == PRE_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pres    <= '0;
      pwm_cnt <= '0;
      mode_q  <= MODE_OFF;
      state_q <= ST_IDLE;
      level_q <= '0;
      sel_q   <= '0;
    end else begin
      pres    <= (change || tick) ? '0 : pres + PRE_W'(1);
      pwm_cnt <= pwm_cnt + WIDTH'(1);
      mode_q  <= mode_in;
      state_q <= state_d;
      level_q <= level_d;
      sel_q   <= sel_d;
    end
  end

  // A mode change takes priority over any tick landing on the same cycle.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    sel_d       = sel_q;
    cycle_pulse = 1'b0;
    if (change) begin
      level_d = '0;
      sel_d   = '0;
      state_d = (mode_in == MODE_SEQ || mode_in == MODE_SYNC) ? ST_RISE : ST_IDLE;
    end else if (tick) begin
      unique case (state_q)
        ST_RISE: begin
          if (level_q == PEAK_L) begin
            state_d = ST_FALL;
            level_d = PEAK_L - WIDTH'(1);
          end else begin
            level_d = level_q + WIDTH'(1);
          end
        end
        ST_FALL: begin
          if (level_q == '0) begin
            state_d = ST_RISE;
            level_d = WIDTH'(1);
            if (mode_q == MODE_SEQ) begin
              if (sel_q == SEL_LAST) begin
                sel_d       = '0;
                cycle_pulse = 1'b1;
              end else begin
                sel_d = sel_q + SEL_W'(1);
              end
            end else if (mode_q == MODE_SYNC) begin
              cycle_pulse = 1'b1;
            end
          end else begin
            level_d = level_q - WIDTH'(1);
          end
        end
        default: begin
          level_d = '0;
          sel_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      duty[c] = '0;
      unique case (mode_q)
        MODE_SEQ:    duty[c] = (sel_q == SEL_W'(c)) ? level_q : '0;
        MODE_SYNC:   duty[c] = level_q;
        MODE_STATIC: duty[c] = i_static[c*WIDTH +: WIDTH];
        default:     duty[c] = '0;
      endcase
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    fader_pwm #(
      .WIDTH(WIDTH)
    ) u_pwm (
      .clk  (i_clk),
      .rst_n(i_reset_n),
      .cnt  (pwm_cnt),
      .duty (duty[c]),
      .pwm  (o_pwm[c])
    );
  end

  assign o_led_n   = ~o_pwm;
  assign o_channel = (mode_q == MODE_SEQ) ? sel_q : '0;
  assign o_cycle   = cycle_pulse;

endmodule

// File: tb/tb_led_fader.sv
// Scoreboard bench for led_fader: a tick-count reference model predicts every
// output each cycle; a negedge monitor pops and compares.
module tb_led_fader;

  localparam int unsigned C = 3;
  localparam int unsigned W = 4;
  localparam int unsigned P = 4;
  localparam int unsigned D = 4;
  localparam int unsigned M = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     mode;
  logic [C*W-1:0] stat;
  logic [C-1:0]   pwm, led_n;
  logic [1:0]     chan;
  logic           cyc;

  always #5 clk = ~clk;

  led_fader #(
    .CHANNELS(C),
    .WIDTH   (W),
    .PEAK    (P),
    .DIVIDER (D)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_mode   (mode),
    .i_static (stat),
    .o_pwm    (pwm),
    .o_led_n  (led_n),
    .o_channel(chan),
    .o_cycle  (cyc)
  );

  typedef struct packed {
    logic [C-1:0] pwm;
    logic [C-1:0] led_n;
    logic [1:0]   chan;
    logic         cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: e = edges since reset, k = edges since last mode change.
  int unsigned  e, k;
  logic [1:0]   mq;
  int unsigned  duty_m [C];
  logic [C-1:0] pwm_m;

  function automatic int unsigned lvl(input int unsigned kk);
    int unsigned p;
    p = (kk / D) % (2 * P);
    return (p <= P) ? p : (2 * P - p);
  endfunction

  function automatic int unsigned selm(input int unsigned kk);
    int unsigned t;
    t = kk / D;
    return (t == 0) ? 0 : ((t - 1) / (2 * P)) % C;
  endfunction

  function automatic int unsigned tgt(input int unsigned c, input logic [1:0] m,
                                      input int unsigned kk, input logic [C*W-1:0] s);
    case (m)
      2'd1:    return (c == selm(kk)) ? lvl(kk) : 0;
      2'd2:    return lvl(kk);
      2'd3:    return int'(s[c*W +: W]);
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    e = 0; k = 0; mq = 2'd0; pwm_m = '0;
    for (int c = 0; c < C; c++) duty_m[c] = 0;
  endtask

  task automatic model_edge();
    int unsigned cnt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    cnt = e % M;
    for (int c = 0; c < C; c++) pwm_m[c] = (cnt < duty_m[c]);
    if (cnt == M - 1)
      for (int c = 0; c < C; c++) duty_m[c] = tgt(c, mq, k, stat);
    if (mode != mq) begin
      mq = mode;
      k  = 0;
    end else begin
      k++;
    end
    e++;
  endtask

  function automatic exp_t expect_now();
    exp_t        x;
    int unsigned tn;
    x.pwm   = pwm_m;
    x.led_n = ~pwm_m;
    x.chan  = (mq == 2'd1) ? 2'(selm(k)) : 2'd0;
    x.cyc   = 1'b0;
    if (rst_n && mode == mq && (mq == 2'd1 || mq == 2'd2) && ((k + 1) % D == 0)) begin
      tn = (k + 1) / D;
      if (tn > 2 * P && ((tn - 1) % (2 * P)) == 0)
        x.cyc = (mq == 2'd2) || ((((tn - 1) / (2 * P)) % C) == 0);
    end
    return x;
  endfunction

  task automatic cycle(input logic r, input logic [1:0] m, input logic [C*W-1:0] s);
    @(posedge clk);
    model_edge();
    #1;
    rst_n = r;
    mode  = m;
    stat  = s;
    if (!r) model_reset();
    q.push_back(expect_now());
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t ex;
    if (q.size() > 0) begin
      ex = q.pop_front();
      check("o_pwm",     pwm,   ex.pwm);
      check("o_led_n",   led_n, ex.led_n);
      check("o_channel", chan,  ex.chan);
      check("o_cycle",   cyc,   ex.cyc);
    end
  end

  initial begin
    logic [C*W-1:0] s1, s2, rs;
    logic [1:0]     rm;
    rst_n = 1'b0;
    mode  = 2'd1;
    stat  = '0;
    model_reset();
    s1 = {4'd15, 4'd8, 4'd0};
    s2 = {4'd15, 4'd3, 4'd0};

    repeat (4)   cycle(1'b0, 2'd1, '0);
    repeat (300) cycle(1'b1, 2'd1, '0);
    repeat (150) cycle(1'b1, 2'd2, '0);
    repeat (50)  cycle(1'b1, 2'd3, s1);
    repeat (40)  cycle(1'b1, 2'd3, s2);
    // SEQ up to level 3, drop to OFF, then restart SEQ
    repeat (13)  cycle(1'b1, 2'd1, s2);
    repeat (40)  cycle(1'b1, 2'd0, s2);
    repeat (120) cycle(1'b1, 2'd1, s2);
    // SYNC into the falling half, then reset and recover
    repeat (24)  cycle(1'b1, 2'd2, '0);
    repeat (3)   cycle(1'b0, 2'd2, '0);
    repeat (60)  cycle(1'b1, 2'd1, '0);

    rm = 2'd1;
    rs = '0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(63) == 0) rm = 2'($urandom_range(3));
      if ($urandom_range(7) == 0)  rs = (C*W)'($urandom);
      if ($urandom_range(399) == 0) begin
        repeat (1 + $urandom_range(1)) cycle(1'b0, rm, rs);
      end
      cycle(1'b1, rm, rs);
    end

    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
